// File: rtl/cpu_datapath_pkg.sv
// Shared encodings for the single-cycle datapath: ALU ops, operand-1 select, writeback select
// and branch conditions, plus the branch-compare helper.
package cpu_datapath_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [1:0] OP1_RS1  = 2'd0;
    localparam logic [1:0] OP1_PC   = 2'd1;
    localparam logic [1:0] OP1_ZERO = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Reserved funct3 encodings (010, 011) are never taken.
    function automatic logic branch_taken(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        logic r_taken;
        r_taken = 1'b0;
        case (f3)
            F3_BEQ:  r_taken = (a == b);
            F3_BNE:  r_taken = (a != b);
            F3_BLT:  r_taken = ($signed(a) < $signed(b));
            F3_BGE:  r_taken = ($signed(a) >= $signed(b));
            F3_BLTU: r_taken = (a < b);
            F3_BGEU: r_taken = (a >= b);
            default: r_taken = 1'b0;
        endcase
        return r_taken;
    endfunction

endpackage

// File: rtl/cpu_datapath_alu.sv
// Combinational 32-bit ALU; unknown op codes produce zero.
module alu
    import cpu_datapath_pkg::*;
(
    input  logic [31:0] i_op1,
    input  logic [31:0] i_op2,
    input  logic [3:0]  i_alu_ctrl,
    output logic [31:0] o_result
);

    logic [4:0] w_shamt;

    assign w_shamt = i_op2[4:0];

    always_comb begin
        o_result = '0;
        case (i_alu_ctrl)
            ALU_ADD:  o_result = i_op1 + i_op2;
            ALU_SUB:  o_result = i_op1 - i_op2;
            ALU_AND:  o_result = i_op1 & i_op2;
            ALU_OR:   o_result = i_op1 | i_op2;
            ALU_XOR:  o_result = i_op1 ^ i_op2;
            ALU_SLL:  o_result = i_op1 << w_shamt;
            ALU_SRL:  o_result = i_op1 >> w_shamt;
            ALU_SRA:  o_result = $unsigned($signed(i_op1) >>> w_shamt);
            ALU_SLT:  o_result = {31'b0, $signed(i_op1) < $signed(i_op2)};
            ALU_SLTU: o_result = {31'b0, i_op1 < i_op2};
            default:  o_result = '0;
        endcase
    end

endmodule

// File: rtl/cpu_datapath_dmem.sv
// Word-addressed data memory, not reset. Byte offset bits are ignored; index wraps at depth.
module dmem #(
    parameter int unsigned DMEM_WORDS = 256
) (
    input  logic        i_clk,
    input  logic        i_we,
    input  logic        i_re,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata
);

    localparam int unsigned AW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

    logic [31:0]   mem [0:DMEM_WORDS-1];
    logic [AW-1:0] w_idx;
    logic          w_unused_addr;

    assign w_idx         = AW'(i_addr[31:2] % 30'(DMEM_WORDS));
    assign w_unused_addr = ^i_addr[1:0];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[w_idx] <= i_wdata;
        end
    end

    assign o_rdata = i_re ? mem[w_idx] : 32'd0;

endmodule

// File: rtl/cpu_datapath_regfile.sv
// 32x32 register file: two combinational read ports, one write port, x0 hardwired to zero.
module regfile (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_raddr1,
    input  logic [4:0]  i_raddr2,
    output logic [31:0] o_rdata1,
    output logic [31:0] o_rdata2
);

    logic [31:0] regs [0:31];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != 5'd0)) begin
            regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 : regs[i_raddr1];
    assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 : regs[i_raddr2];

endmodule

// File: rtl/cpu_datapath.sv
// Single-cycle RV32I-style datapath top: PC, instruction ROM, regfile, ALU, branch unit, dmem.
// Define DATAPATH_TRACE_EN for a simulation-only per-edge trace of PC, instr and writes.
module cpu_datapath
    import cpu_datapath_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 256,
    parameter int unsigned DMEM_WORDS = 256,
    parameter string       IMEM_INIT  = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [6:0]  funct7,
    input  logic [19:0] csr,
    input  logic [3:0]  alu_ctrl,
    input  logic [31:0] imm_out,
    input  logic        reg_write,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        alu_src,
    input  logic [1:0]  op1_sel,
    input  logic [1:0]  wb_sel,
    input  logic        is_branch,
    input  logic        is_jal,
    input  logic        is_jalr,
    output logic [31:0] instr
);

    localparam int unsigned IMEM_AW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;

    logic [31:0]        pc_current;
    logic [31:0]        imem [0:IMEM_WORDS-1];
    logic [IMEM_AW-1:0] w_imem_idx;

    logic [31:0] w_rs1_data;
    logic [31:0] w_rs2_data;
    logic [31:0] w_op1;
    logic [31:0] w_op2;
    logic [31:0] w_alu_result;
    logic [31:0] w_mem_rdata;
    logic [31:0] w_wb_data;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_target;
    logic [31:0] w_jalr_target;
    logic [31:0] w_pc_next;
    logic        w_taken;
    logic        w_dmem_we;
    logic        w_unused_inputs;

    assign w_unused_inputs = ^{opcode, funct7, csr};

    assign w_imem_idx = IMEM_AW'(pc_current[31:2] % 30'(IMEM_WORDS));
    assign instr      = imem[w_imem_idx];

    regfile u_rf (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_we     (reg_write),
        .i_waddr  (rd),
        .i_wdata  (w_wb_data),
        .i_raddr1 (rs1),
        .i_raddr2 (rs2),
        .o_rdata1 (w_rs1_data),
        .o_rdata2 (w_rs2_data)
    );

    always_comb begin
        w_op1 = 32'd0;
        case (op1_sel)
            OP1_RS1: w_op1 = w_rs1_data;
            OP1_PC:  w_op1 = pc_current;
            default: w_op1 = 32'd0;
        endcase
    end

    assign w_op2 = alu_src ? imm_out : w_rs2_data;

    alu u_alu (
        .i_op1      (w_op1),
        .i_op2      (w_op2),
        .i_alu_ctrl (alu_ctrl),
        .o_result   (w_alu_result)
    );

    // Async reset already holds the regfile; the memory has no reset so gate its write here.
    assign w_dmem_we = mem_write && !reset;

    dmem #(
        .DMEM_WORDS (DMEM_WORDS)
    ) u_dmem (
        .i_clk   (clk),
        .i_we    (w_dmem_we),
        .i_re    (mem_read),
        .i_addr  (w_alu_result),
        .i_wdata (w_rs2_data),
        .o_rdata (w_mem_rdata)
    );

    assign w_pc_plus4 = pc_current + 32'd4;

    always_comb begin
        w_wb_data = w_alu_result;
        case (wb_sel)
            WB_ALU:  w_wb_data = w_alu_result;
            WB_MEM:  w_wb_data = w_mem_rdata;
            WB_PC4:  w_wb_data = w_pc_plus4;
            WB_IMM:  w_wb_data = imm_out;
            default: w_wb_data = w_alu_result;
        endcase
    end

    assign w_taken       = branch_taken(funct3, w_rs1_data, w_rs2_data);
    assign w_pc_target   = pc_current + imm_out;
    assign w_jalr_target = (w_rs1_data + imm_out) & 32'hFFFF_FFFE;

    always_comb begin
        w_pc_next = w_pc_plus4;
        if (is_jalr) begin
            w_pc_next = w_jalr_target;
        end else if (is_jal) begin
            w_pc_next = w_pc_target;
        end else if (is_branch && w_taken) begin
            w_pc_next = w_pc_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_current <= 32'd0;
        end else begin
            pc_current <= w_pc_next;
        end
    end

`ifdef DATAPATH_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            $display("[trace] pc=%08h instr=%08h", pc_current, instr);
            if (reg_write && (rd != 5'd0)) begin
                $display("[trace]   x%0d <= %08h", rd, w_wb_data);
            end
            if (mem_write) begin
                $display("[trace]   mem[%08h] <= %08h", w_alu_result, w_rs2_data);
            end
        end
    end
`endif

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath: hand-computed PC, register and memory values per step.
module tb_cpu_datapath;
    import cpu_datapath_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [19:0] csr;
    logic [3:0]  alu_ctrl;
    logic [31:0] imm_out;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
    logic [1:0]  op1_sel;
    logic [1:0]  wb_sel;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic [31:0] instr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_datapath dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .rd        (rd),
        .funct3    (funct3),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct7    (funct7),
        .csr       (csr),
        .alu_ctrl  (alu_ctrl),
        .imm_out   (imm_out),
        .reg_write (reg_write),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .alu_src   (alu_src),
        .op1_sel   (op1_sel),
        .wb_sel    (wb_sel),
        .is_branch (is_branch),
        .is_jal    (is_jal),
        .is_jalr   (is_jalr),
        .instr     (instr)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] expected);
        checks++;
        if (act !== expected) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, act, expected);
        end
    endtask

    task automatic clear_ctrl();
        opcode = '0; rd = '0; funct3 = '0; rs1 = '0; rs2 = '0; funct7 = '0; csr = '0;
        alu_ctrl = '0; imm_out = '0; reg_write = 0; mem_read = 0; mem_write = 0; alu_src = 0;
        op1_sel = '0; wb_sel = '0; is_branch = 0; is_jal = 0; is_jalr = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clear_ctrl();
    endtask

    task automatic alu_i(input logic [4:0] d, input logic [4:0] s1, input logic [31:0] imm,
                         input logic [3:0] op);
        rd = d; rs1 = s1; imm_out = imm; alu_ctrl = op; alu_src = 1; reg_write = 1;
        step();
    endtask

    task automatic alu_r(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [3:0] op);
        rd = d; rs1 = s1; rs2 = s2; alu_ctrl = op; reg_write = 1;
        step();
    endtask

    task automatic branch(input logic [2:0] f3, input logic [4:0] s1, input logic [4:0] s2,
                          input logic [31:0] imm);
        funct3 = f3; rs1 = s1; rs2 = s2; imm_out = imm; is_branch = 1;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        clear_ctrl();
        reset = 1'b1;
        dut.imem[0] = 32'h0000_0013;
        dut.imem[2] = 32'hDEAD_BEEF;
        dut.imem[3] = 32'h1234_5678;
        dut.u_dmem.mem[8] = 32'hCAFE_0000;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_pc", dut.pc_current, 32'd0);
        check_eq("rst_instr", instr, 32'h0000_0013);
        check_eq("rst_x5", dut.u_rf.regs[5], 32'd0);
        reset = 1'b0;

        alu_i(5, 0, 32'd123, ALU_ADD);
        check_eq("addi_x5", dut.u_rf.regs[5], 32'd123);
        check_eq("pc_4", dut.pc_current, 32'd4);
        step();
        check_eq("nop_pc", dut.pc_current, 32'd8);
        check_eq("instr_pc8", instr, 32'hDEAD_BEEF);

        rs2 = 5; imm_out = 32'h10; alu_src = 1; alu_ctrl = ALU_ADD; mem_write = 1;
        step();
        check_eq("store_mem4", dut.u_dmem.mem[4], 32'd123);
        check_eq("store_x5_kept", dut.u_rf.regs[5], 32'd123);

        rd = 6; imm_out = 32'h10; alu_src = 1; mem_read = 1; wb_sel = WB_MEM; reg_write = 1;
        step();
        check_eq("load_x6", dut.u_rf.regs[6], 32'd123);
        rd = 7; imm_out = 32'h10; alu_src = 1; mem_read = 0; wb_sel = WB_MEM; reg_write = 1;
        step();
        check_eq("load_noread_x7", dut.u_rf.regs[7], 32'd0);
        check_eq("pc_20", dut.pc_current, 32'd20);

        alu_i(8, 5, 32'd7, ALU_ADD);
        check_eq("add_x8", dut.u_rf.regs[8], 32'd130);
        alu_r(9, 8, 5, ALU_SUB);
        check_eq("sub_x9", dut.u_rf.regs[9], 32'd7);
        alu_i(10, 5, 32'hF, ALU_AND);
        check_eq("and_x10", dut.u_rf.regs[10], 32'd11);
        alu_i(11, 5, 32'd2, ALU_SLL);
        check_eq("sll_x11", dut.u_rf.regs[11], 32'd492);
        alu_i(11, 11, 32'd1, ALU_SRL);
        check_eq("srl_x11_rbw", dut.u_rf.regs[11], 32'd246);
        alu_i(12, 0, 32'hFFFF_FF80, ALU_ADD);
        check_eq("neg_x12", dut.u_rf.regs[12], 32'hFFFF_FF80);
        alu_i(13, 12, 32'd2, ALU_SRA);
        check_eq("sra_x13", dut.u_rf.regs[13], 32'hFFFF_FFE0);
        alu_i(14, 12, 32'd2, ALU_SRL);
        check_eq("srl_x14", dut.u_rf.regs[14], 32'h3FFF_FFE0);
        alu_r(15, 12, 5, ALU_SLT);
        check_eq("slt_x15", dut.u_rf.regs[15], 32'd1);
        alu_r(16, 12, 5, ALU_SLTU);
        check_eq("sltu_x16", dut.u_rf.regs[16], 32'd0);
        alu_i(17, 5, 32'hFF, ALU_XOR);
        check_eq("xor_x17", dut.u_rf.regs[17], 32'h84);
        alu_i(18, 5, 32'h100, ALU_OR);
        check_eq("or_x18", dut.u_rf.regs[18], 32'h17B);
        alu_i(10, 5, 32'd1, 4'hA);
        check_eq("undef_alu_x10", dut.u_rf.regs[10], 32'd0);
        check_eq("pc_72", dut.pc_current, 32'd72);

        rd = 20; imm_out = 32'h1234_5000; wb_sel = WB_IMM; reg_write = 1;
        step();
        check_eq("wbimm_x20", dut.u_rf.regs[20], 32'h1234_5000);
        rd = 21; op1_sel = OP1_PC; imm_out = 32'h100; alu_src = 1; reg_write = 1;
        step();
        check_eq("auipc_x21", dut.u_rf.regs[21], 32'h14C);
        rd = 22; wb_sel = WB_PC4; reg_write = 1;
        step();
        check_eq("wbpc4_x22", dut.u_rf.regs[22], 32'd84);

        branch(F3_BEQ, 6, 6, 32'd16);
        check_eq("beq_taken", dut.pc_current, 32'd100);
        branch(F3_BNE, 5, 5, 32'd24);
        check_eq("bne_not", dut.pc_current, 32'd104);
        branch(F3_BLT, 12, 5, 32'd8);
        check_eq("blt_taken", dut.pc_current, 32'd112);
        branch(F3_BLTU, 12, 5, 32'd8);
        check_eq("bltu_not", dut.pc_current, 32'd116);
        branch(F3_BGE, 5, 12, 32'hFFFF_FFFC);
        check_eq("bge_back", dut.pc_current, 32'd112);
        branch(F3_BGEU, 5, 12, 32'd8);
        check_eq("bgeu_not", dut.pc_current, 32'd116);
        branch(3'b010, 6, 6, 32'd8);
        check_eq("f3_rsvd_not", dut.pc_current, 32'd120);

        rd = 1; imm_out = 32'd40; is_jal = 1; wb_sel = WB_PC4; reg_write = 1;
        step();
        check_eq("jal_x1", dut.u_rf.regs[1], 32'd124);
        check_eq("jal_pc", dut.pc_current, 32'd160);
        rd = 2; rs1 = 5; imm_out = 32'd8; is_jalr = 1; wb_sel = WB_PC4; reg_write = 1;
        step();
        check_eq("jalr_x2", dut.u_rf.regs[2], 32'd164);
        check_eq("jalr_pc", dut.pc_current, 32'd130);
        imm_out = 32'h41; is_jalr = 1; is_jal = 1;
        step();
        check_eq("jalr_prio", dut.pc_current, 32'h40);
        imm_out = 32'hFFFF_FFFC; is_jalr = 1;
        step();
        check_eq("pc_top", dut.pc_current, 32'hFFFF_FFFC);
        step();
        check_eq("pc_wrap", dut.pc_current, 32'd0);

        alu_i(0, 0, 32'd55, ALU_ADD);
        check_eq("x0_ignored", dut.u_rf.regs[0], 32'd0);
        alu_i(24, 0, 32'd1, ALU_ADD);
        check_eq("x0_reads0", dut.u_rf.regs[24], 32'd1);
        rs2 = 8; imm_out = 32'h413; alu_src = 1; mem_write = 1;
        step();
        check_eq("dmem_wrap", dut.u_dmem.mem[4], 32'd130);
        check_eq("instr_pc12", instr, 32'h1234_5678);

        reset = 1'b1;
        #1;
        check_eq("midrst_pc", dut.pc_current, 32'd0);
        check_eq("midrst_x5", dut.u_rf.regs[5], 32'd0);
        check_eq("midrst_x24", dut.u_rf.regs[24], 32'd0);
        rd = 25; rs2 = 5; imm_out = 32'h20; alu_src = 1; mem_write = 1; reg_write = 1;
        step();
        check_eq("rst_no_store", dut.u_dmem.mem[8], 32'hCAFE_0000);
        check_eq("rst_no_regwr", dut.u_rf.regs[25], 32'd0);
        check_eq("rst_pc_hold", dut.pc_current, 32'd0);
        reset = 1'b0;
        step();
        check_eq("post_rst_pc", dut.pc_current, 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
